ks42_stream_accumulator: RTL and testbench
==========================================

// Module: ks42_stream_accumulator
// PURPOSE
//  Streaming front-end for the 42-bit sparse Kogge-Stone adder (sparse_42bitks).
//  Accepts a burst of 42-bit operands over a valid/ready handshake, feeds
//  {acc, operand} to one internal sparse_42bitks instance each beat, and
//  registers the result. On the last beat, it presents the total sum with a
//  beat count and a wrap flag. Sits between the operand source and the result sink.
// PARAMETERS
//  CNT_W   8   width of out_count; the beat counter saturates at 2**CNT_W-1
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous active-low reset
//  clear      in   1      synchronous abort: drop the burst, return to ACCUM
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept an operand
//  in_data    in   42     unsigned operand
//  in_last    in   1      final operand of the burst (qualified by the handshake)
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts the result
//  out_sum    out  42     sum of all burst operands, modulo 2**42
//  out_count  out  CNT_W  beats accepted in the burst (saturating)
//  out_wrap   out  1      at least one addition wrapped past 2**42-1
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - state=ACCUM, acc=0, count=0, wrap=0.
//   - in_ready=1, out_valid=0, out_sum=0, out_count=0, out_wrap=0.
//  Arithmetic
//   - next_acc = sparse_42bitks(acc, in_data). The adder has no carry-out, so the result is mod 2**42.
//   - Beat wrap = (next_acc < acc), an unsigned compare; wrap is sticky OR-ed per burst.
//   - count += 1 per accepted beat; it holds at 2**CNT_W-1.
//  State ACCUM
//   - in_ready=1, out_valid=0.
//   - Beat = in_valid & in_ready: acc<=next_acc; count and wrap update.
//   - Beat with in_last=1: latch out_sum, out_count and out_wrap from the post-beat
//     values, then go to HOLD.
//   - Latency: the result is valid the cycle after the last beat (1 clk).
//  State HOLD
//   - in_ready=0, out_valid=1. out_* are held stable until accepted.
//   - out_valid & out_ready: acc, count and wrap clear to 0, out_valid drops the next
//     cycle, and the state returns to ACCUM. in_ready=1 from that cycle on.
//   - No input is accepted in the same cycle as result acceptance (no bypass).
//  clear
//   - Takes priority over any beat or acceptance in that cycle.
//   - acc, count and wrap clear to 0; state goes to ACCUM; out_valid goes to 0.
//   - out_sum, out_count and out_wrap keep their last values.
//  Boundary conditions
//   - A single-beat burst (in_last on the first beat) gives out_sum=in_data and out_count=1.
//   - in_valid=0 cycles inside a burst leave all state unchanged.
//   - in_data and in_last are ignored when in_valid=0 or the block is in HOLD.
//   - rst_n asserted mid-burst or in HOLD aborts immediately to the reset values;
//     the partial sum is lost.
//   - Wrap example: acc=3FF_FFFF_FFFF plus operand 1 gives acc=0 and wrap=1.
// TESTING
//  T1 Beats 5, 7, 9 (last on 9), out_ready=1 -> out_sum=21, count=3, wrap=0,
//     out_valid asserted exactly 1 cycle after the beat.
//  T2 Beats 3FF_FFFF_FFFF and 2 (last) -> out_sum=1, count=2, wrap=1; the next
//     burst of 4 (last) -> sum=4, wrap=0 (sticky flag cleared between bursts).
//  T3 Hold out_ready=0 for 10 cycles in HOLD while driving in_valid=1 ->
//     in_ready=0, out_* stable, acc unchanged; then out_ready=1 -> accepted,
//     in_ready=1 on the next cycle.
//  T4 Issue clear after beats 100 and 200, then beat 7 (last) -> out_sum=7, count=1.
//  T5 Pulse rst_n low asynchronously mid-burst, between clock edges -> all
//     outputs at reset values immediately; a burst 1 (last) afterwards -> sum=1.
//  T6 Random 1-300 beat bursts with random valid/ready gaps and CNT_W=8 ->
//     matches the reference model (sum mod 2**42, count saturating at 255, wrap).

Source files
------------

// File: rtl/ks42_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : ks42_stream_accumulator (with sparse_42bitks adder)
//  Brief    : Accumulates a valid/ready operand burst through a sparse
//             Kogge-Stone adder and presents sum, beat count and wrap flag.
//  Revision : 1.0 - initial release
// ============================================================================

module sparse_42bitks (
    input  logic [41:0] a,
    input  logic [41:0] b,
    output logic [41:0] sum
);
    // The top bit's generate would only feed the discarded carry-out.
    logic [40:0] w_g;
    logic [41:0] w_p;
    logic [41:0] w_c;
    logic [9:0]  w_gg0, w_gg1, w_gg2, w_gg3, w_gg4;
    logic [9:1]  w_gp0;
    logic [9:2]  w_gp1;
    logic [9:4]  w_gp2;
    logic [9:8]  w_gp3;

    assign w_g = a[40:0] & b[40:0];
    assign w_p = a ^ b;

    // Ten 4-bit groups feed the prefix tree; bits 41:40 only ripple off group 9.
    // Group propagates touching bit 0 are never needed because carry-in is zero.
    generate
        for (genvar k = 0; k < 10; k++) begin : g_grp
            assign w_gg0[k] = w_g[4*k+3]
                            | (w_p[4*k+3] & w_g[4*k+2])
                            | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                            | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            if (k >= 1) begin : g_p0
                assign w_gp0[k] = &w_p[4*k+3 -: 4];
            end

            if (k >= 1) begin : g_l1
                assign w_gg1[k] = w_gg0[k] | (w_gp0[k] & w_gg0[k-1]);
            end else begin : g_l1_pass
                assign w_gg1[k] = w_gg0[k];
            end
            if (k >= 2) begin : g_l1p
                assign w_gp1[k] = w_gp0[k] & w_gp0[k-1];
            end

            if (k >= 2) begin : g_l2
                assign w_gg2[k] = w_gg1[k] | (w_gp1[k] & w_gg1[k-2]);
            end else begin : g_l2_pass
                assign w_gg2[k] = w_gg1[k];
            end
            if (k >= 4) begin : g_l2p
                assign w_gp2[k] = w_gp1[k] & w_gp1[k-2];
            end

            if (k >= 4) begin : g_l3
                assign w_gg3[k] = w_gg2[k] | (w_gp2[k] & w_gg2[k-4]);
            end else begin : g_l3_pass
                assign w_gg3[k] = w_gg2[k];
            end
            if (k >= 8) begin : g_l3p
                assign w_gp3[k] = w_gp2[k] & w_gp2[k-4];
            end

            if (k >= 8) begin : g_l4
                assign w_gg4[k] = w_gg3[k] | (w_gp3[k] & w_gg3[k-8]);
            end else begin : g_l4_pass
                assign w_gg4[k] = w_gg3[k];
            end
        end

        assign w_c[0] = 1'b0;
        for (genvar i = 1; i < 42; i++) begin : g_carry
            if (i % 4 == 0) begin : g_grp_cin
                assign w_c[i] = w_gg4[i/4-1];
            end else begin : g_ripple
                assign w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
            end
        end
    endgenerate

    assign sum = w_p ^ w_c;
endmodule

module ks42_stream_accumulator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [41:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [41:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_wrap
);
    localparam logic [0:0]       c_st_accum = 1'b0;
    localparam logic [0:0]       c_st_hold  = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [41:0]      r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_wrap;
    logic [41:0]      r_out_sum;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_wrap;

    logic [41:0]      w_next_acc;
    logic             w_beat;
    logic             w_next_wrap;
    logic [CNT_W-1:0] w_next_count;

    sparse_42bitks u_adder (
        .a   (r_acc),
        .b   (in_data),
        .sum (w_next_acc)
    );

    assign in_ready     = (r_state == c_st_accum);
    assign out_valid    = (r_state == c_st_hold);
    assign w_beat       = in_valid & in_ready;
    // A modulo-2**42 sum smaller than its starting value means the carry-out was lost.
    assign w_next_wrap  = r_wrap | (w_next_acc < r_acc);
    assign w_next_count = (r_count == c_cnt_max) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_accum;
            r_acc       <= '0;
            r_count     <= '0;
            r_wrap      <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_wrap  <= 1'b0;
        end else if (clear) begin
            r_state <= c_st_accum;
            r_acc   <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_beat) begin
            r_acc   <= w_next_acc;
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
            if (in_last) begin
                r_out_sum   <= w_next_acc;
                r_out_count <= w_next_count;
                r_out_wrap  <= w_next_wrap;
                r_state     <= c_st_hold;
            end
        end else if ((r_state == c_st_hold) && out_ready) begin
            r_state <= c_st_accum;
            r_acc   <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end
    end

    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_wrap  = r_out_wrap;
endmodule
`default_nettype wire

// File: tb/tb_ks42_stream_accumulator.sv
`default_nettype none
// Self-checking bench for ks42_stream_accumulator: directed scenarios plus
// randomized bursts checked against a plain-arithmetic reference.
module tb_ks42_stream_accumulator;
    localparam int         CNT_W = 8;
    localparam logic [41:0] MAXV = 42'h3FF_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n, clear, in_valid, in_ready, in_last;
    logic             out_valid, out_ready, out_wrap;
    logic [41:0]      in_data, out_sum;
    logic [CNT_W-1:0] out_count;
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    ks42_stream_accumulator #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_wrap(out_wrap)
    );

    task automatic send(input logic [41:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        n_cmp++;
        if (!in_ready) begin n_err++; $display("FAIL send_ready_timeout got in_ready=%0b exp 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 42'({$urandom, $urandom}); in_last = 1'($urandom);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        n_cmp++; if (out_sum !== 42'd0) begin n_err++; $display("FAIL rst_out_sum got %0h exp 0", out_sum); end
        n_cmp++; if (out_count !== '0) begin n_err++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
        n_cmp++; if (out_wrap !== 1'b0) begin n_err++; $display("FAIL rst_out_wrap got %0b exp 0", out_wrap); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(42'd5, 1'b0);
        send(42'd7, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid got %0b exp 0", out_valid); end
        send(42'd9, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t1_latency got out_valid=%0b exp 1", out_valid); end
        n_cmp++; if (out_sum !== 42'd21) begin n_err++; $display("FAIL t1_sum got %0d exp 21", out_sum); end
        n_cmp++; if (out_count !== 8'd3) begin n_err++; $display("FAIL t1_count got %0d exp 3", out_count); end
        n_cmp++; if (out_wrap !== 1'b0) begin n_err++; $display("FAIL t1_wrap got %0b exp 0", out_wrap); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t1_hold_ready got %0b exp 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL t1_accept got v/r=%b exp 01", {out_valid, in_ready}); end
    endtask

    task automatic test_wrap();
        send(MAXV, 1'b0);
        send(42'd2, 1'b1);
        wait_valid();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid_timeout got %0b exp 1", out_valid); end
        n_cmp++; if (out_sum !== 42'd1) begin n_err++; $display("FAIL t2_sum got %0h exp 1", out_sum); end
        n_cmp++; if (out_count !== 8'd2) begin n_err++; $display("FAIL t2_count got %0d exp 2", out_count); end
        n_cmp++; if (out_wrap !== 1'b1) begin n_err++; $display("FAIL t2_wrap got %0b exp 1", out_wrap); end
        accept();
        send(42'd4, 1'b1);
        wait_valid();
        n_cmp++; if (out_sum !== 42'd4) begin n_err++; $display("FAIL t2b_sum got %0h exp 4", out_sum); end
        n_cmp++; if (out_count !== 8'd1) begin n_err++; $display("FAIL t2b_count got %0d exp 1", out_count); end
        n_cmp++; if (out_wrap !== 1'b0) begin n_err++; $display("FAIL t2b_wrap_sticky got %0b exp 0", out_wrap); end
        accept();
    endtask

    task automatic test_hold();
        send(42'd11, 1'b0);
        send(42'd22, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 42'({$urandom, $urandom}); in_last = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if ({in_ready, out_valid, out_sum, out_count, out_wrap} !== {1'b0, 1'b1, 42'd33, 8'd2, 1'b0}) begin
                n_err++;
                $display("FAIL t3_hold_stable cyc %0d got r=%0b v=%0b sum=%0d cnt=%0d wrap=%0b exp r=0 v=1 sum=33 cnt=2 wrap=0",
                         i, in_ready, out_valid, out_sum, out_count, out_wrap);
            end
        end
        in_data = 42'd1000;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL t3_accept got v/r=%b exp 01", {out_valid, in_ready}); end
        send(42'd6, 1'b1);
        wait_valid();
        n_cmp++; if (out_sum !== 42'd6) begin n_err++; $display("FAIL t3_no_bypass_sum got %0d exp 6", out_sum); end
        n_cmp++; if (out_count !== 8'd1) begin n_err++; $display("FAIL t3_no_bypass_count got %0d exp 1", out_count); end
        accept();
    endtask

    task automatic test_clear();
        send(42'd100, 1'b0);
        send(42'd200, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 42'd50; in_last = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL t4_clear_state got v/r=%b exp 01", {out_valid, in_ready}); end
        n_cmp++; if ({out_sum, out_count} !== {42'd6, 8'd1}) begin n_err++; $display("FAIL t4_clear_keeps_out got sum=%0d cnt=%0d exp sum=6 cnt=1", out_sum, out_count); end
        send(42'd7, 1'b1);
        wait_valid();
        n_cmp++; if (out_sum !== 42'd7) begin n_err++; $display("FAIL t4_sum got %0d exp 7", out_sum); end
        n_cmp++; if (out_count !== 8'd1) begin n_err++; $display("FAIL t4_count got %0d exp 1", out_count); end
        clear = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; out_ready = 1'b0;
        n_cmp++; if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, 42'd7}) begin n_err++; $display("FAIL t4_clear_hold got v=%0b r=%0b sum=%0d exp v=0 r=1 sum=7", out_valid, in_ready, out_sum); end
        send(42'd8, 1'b1);
        wait_valid();
        n_cmp++; if ({out_sum, out_count} !== {42'd8, 8'd1}) begin n_err++; $display("FAIL t4b_result got sum=%0d cnt=%0d exp sum=8 cnt=1", out_sum, out_count); end
        accept();
    endtask

    task automatic test_async_reset();
        send(42'd10, 1'b0);
        send(42'd20, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_sum, out_count, out_wrap} !== {1'b1, 1'b0, 42'd0, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL t5_async_mid got r=%0b v=%0b sum=%0d cnt=%0d wrap=%0b exp r=1 v=0 sum=0 cnt=0 wrap=0",
                     in_ready, out_valid, out_sum, out_count, out_wrap);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send(42'd1, 1'b1);
        wait_valid();
        n_cmp++; if ({out_sum, out_count} !== {42'd1, 8'd1}) begin n_err++; $display("FAIL t5_after_sum got sum=%0d cnt=%0d exp sum=1 cnt=1", out_sum, out_count); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_sum} !== {1'b0, 42'd0}) begin n_err++; $display("FAIL t5_async_hold got v=%0b sum=%0d exp v=0 sum=0", out_valid, out_sum); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            logic [41:0]     ops[$];
            longint unsigned total = 0;
            int              n     = (b == 0) ? 300 : (b == 1) ? 255 : int'($urandom_range(1, 300));
            int              mode  = int'($urandom_range(0, 2));
            int              idx   = 0;
            int              guard = 0;
            logic [41:0]     exp_sum;
            logic [CNT_W-1:0] exp_cnt;
            logic            exp_wrap;
            for (int i = 0; i < n; i++) begin
                logic [41:0] op;
                if (mode == 0)      op = 42'($urandom_range(0, 100000));
                else if (mode == 1) op = 42'({$urandom, $urandom});
                else                op = MAXV - 42'($urandom_range(0, 15));
                ops.push_back(op);
                total += longint'(op);
            end
            exp_sum  = total[41:0];
            exp_wrap = (total >= (64'd1 << 42));
            exp_cnt  = (n > 255) ? 8'd255 : 8'(n);
            while (idx < n && guard < 5000) begin
                logic v = ($urandom_range(0, 3) != 0);
                in_valid  = v;
                in_data   = v ? ops[idx] : 42'({$urandom, $urandom});
                in_last   = v ? (idx == n - 1) : 1'($urandom);
                out_ready = 1'($urandom);
                if (v && in_ready) idx++;
                @(posedge clk); #1;
                guard++;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            wait_valid();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t6_valid burst %0d got %0b exp 1", b, out_valid); end
            n_cmp++;
            if ({out_sum, out_count, out_wrap} !== {exp_sum, exp_cnt, exp_wrap}) begin
                n_err++;
                $display("FAIL t6_result burst %0d n=%0d got sum=%0h cnt=%0d wrap=%0b exp sum=%0h cnt=%0d wrap=%0b",
                         b, n, out_sum, out_count, out_wrap, exp_sum, exp_cnt, exp_wrap);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
